// File: rtl/icache_pkg.sv
// Shared constants, refill state encoding and tag-entry layout for the
// instruction-cache line-fill engine.
package icache_pkg;

   localparam int LINE_WORDS = 8;
   localparam int RAM_AW     = 10;
   localparam int MAX_BURSTS = 1;
   localparam int OFFSET_W   = $clog2(LINE_WORDS);
   localparam int INDEX_W    = RAM_AW - OFFSET_W;
   localparam int TAG_W      = 32 - RAM_AW - 2;

   // Bit positions of the offset, index and tag fields in a byte address
   localparam int OFF_LSB = 2;
   localparam int IDX_LSB = OFF_LSB + OFFSET_W;
   localparam int TAG_LSB = IDX_LSB + INDEX_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INVAL,
      ST_REQ,
      ST_FILL,
      ST_FINISH
   } refill_state_t;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
   } tag_entry_t;

endpackage

// File: rtl/icache_refill.sv
// Line-fill engine: invalidates the tag, bursts a line from memory into the
// data RAM, forwards the critical word and revalidates the tag on success.
module icache_refill
   import icache_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                miss_valid_i,
   input  logic [31:0]         miss_addr_i,
   output logic                miss_ready_o,
   output logic                mem_rd_o,
   output logic [31:0]         mem_addr_o,
   output logic [7:0]          mem_len_o,
   input  logic                mem_accept_i,
   input  logic                mem_valid_i,
   input  logic [31:0]         mem_data_i,
   input  logic                mem_last_i,
   input  logic                mem_error_i,
   output logic                ram_wr_o,
   output logic [RAM_AW-1:0]   ram_addr_o,
   output logic [31:0]         ram_data_o,
   output logic                tag_wr_o,
   output logic [INDEX_W-1:0]  tag_idx_o,
   output logic [TAG_W:0]      tag_data_o,
   output logic                fwd_valid_o,
   output logic [31:0]         fwd_data_o,
   output logic                done_o,
   output logic                error_o
);

   refill_state_t         state_q, state_d;
   logic [31:OFF_LSB]     addr_q, addr_d;
   logic [OFFSET_W-1:0]   beat_q, beat_d;
   logic                  err_q, err_d;
   logic                  miss_ready_q, miss_ready_d;
   logic                  mem_rd_q, mem_rd_d;
   logic [31:0]           mem_addr_q, mem_addr_d;
   logic [7:0]            mem_len_q, mem_len_d;
   logic                  tag_wr_q, tag_wr_d;
   logic [INDEX_W-1:0]    tag_idx_q, tag_idx_d;
   tag_entry_t            tag_data_q, tag_data_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;

   logic                  fill_beat;
   logic                  beat_last;
   logic                  beat_ok;
   logic                  unused_byte_bits;

   assign unused_byte_bits = ^miss_addr_i[OFF_LSB-1:0];

   assign fill_beat = (state_q == ST_FILL) && mem_valid_i;
   assign beat_last = (beat_q == OFFSET_W'(LINE_WORDS - 1));
   // Once an error has been seen no further data reaches the RAM or fetch stage
   assign beat_ok   = fill_beat && !err_q && !mem_error_i;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      beat_d  = beat_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (miss_valid_i) begin
               addr_d  = miss_addr_i[31:OFF_LSB];
               beat_d  = '0;
               err_d   = 1'b0;
               state_d = ST_INVAL;
            end
         end
         ST_INVAL: state_d = ST_REQ;
         ST_REQ: begin
            if (mem_accept_i) begin
               beat_d  = '0;
               state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            if (mem_valid_i) begin
               beat_d = beat_q + 1'b1;
               err_d  = err_q | mem_error_i | (mem_last_i && !beat_last);
               if (mem_last_i || beat_last) begin
                  beat_d  = '0;
                  state_d = ST_FINISH;
               end
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      // Registered outputs are decoded from the state being entered
      miss_ready_d = (state_d == ST_IDLE);
      mem_rd_d     = (state_d == ST_REQ);
      mem_addr_d   = mem_rd_d ? {addr_d[31:IDX_LSB], {IDX_LSB{1'b0}}} : '0;
      mem_len_d    = mem_rd_d ? 8'(LINE_WORDS - 1) : '0;
      tag_wr_d     = (state_d == ST_INVAL) || ((state_d == ST_FINISH) && !err_d);
      tag_idx_d    = tag_wr_d ? addr_d[TAG_LSB-1:IDX_LSB] : '0;
      tag_data_d   = '0;
      if (tag_wr_d) begin
         tag_data_d.valid = (state_d == ST_FINISH);
         tag_data_d.tag   = addr_d[31:TAG_LSB];
      end
      done_d  = (state_d == ST_FINISH);
      error_d = done_d && err_d;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         beat_q       <= '0;
         err_q        <= 1'b0;
         miss_ready_q <= 1'b0;
         mem_rd_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_len_q    <= '0;
         tag_wr_q     <= 1'b0;
         tag_idx_q    <= '0;
         tag_data_q   <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         beat_q       <= beat_d;
         err_q        <= err_d;
         miss_ready_q <= miss_ready_d;
         mem_rd_q     <= mem_rd_d;
         mem_addr_q   <= mem_addr_d;
         mem_len_q    <= mem_len_d;
         tag_wr_q     <= tag_wr_d;
         tag_idx_q    <= tag_idx_d;
         tag_data_q   <= tag_data_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign miss_ready_o = miss_ready_q;
   assign mem_rd_o     = mem_rd_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_len_o    = mem_len_q;
   assign tag_wr_o     = tag_wr_q;
   assign tag_idx_o    = tag_idx_q;
   assign tag_data_o   = tag_data_q;
   assign done_o       = done_q;
   assign error_o      = error_q;

   // Beat data goes straight through so the critical word costs no extra cycle
   assign ram_wr_o    = beat_ok;
   assign ram_addr_o  = beat_ok ? {addr_q[TAG_LSB-1:IDX_LSB], beat_q} : '0;
   assign ram_data_o  = beat_ok ? mem_data_i : '0;
   assign fwd_valid_o = beat_ok && (beat_q == addr_q[IDX_LSB-1:OFF_LSB]);
   assign fwd_data_o  = fwd_valid_o ? mem_data_i : '0;

endmodule
